// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder
//   One TMDS channel encoder. It runs in the pixel clock domain and produces one 10-bit
//   symbol per clock for a 10:1 serializer. Video pixels are 8b/10b DVI encoded with
//   running-disparity balance. Control periods send the four fixed control symbols.
//   The pipeline has two stages: transition minimisation, then DC balance and symbol select.
//
// Build option
//   TMDS_TERC4_EN : when defined, island=1 during de=0 sends TERC4(aux). When it is not
//                   defined, island and aux are ignored and the output is pure DVI.
//
// Parameters
//   INIT_CTRL    control code whose symbol is driven on tmds while in reset
//   BIT_REVERSE  1 = drive tmds in reversed bit order for LSB-last serializers
//
// Ports
//   clk      pixel clock
//   resetn   synchronous active-low reset
//   de       video data enable
//   data     pixel component (used when de=1)
//   ctrl     control code (used when de=0)
//   island   data-island period (TERC4 builds only)
//   aux      TERC4 nibble (TERC4 builds only)
//   tmds     encoded symbol, bit 0 transmitted first
module tmds_channel_encoder #(
  parameter logic [1:0] INIT_CTRL   = 2'b00,
  parameter bit         BIT_REVERSE = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic       island,
  input  logic [3:0] aux,
  output logic [9:0] tmds
);

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_sym(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction
`endif

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] n1_d;
  logic       xnor_sel;
  logic [8:0] qm_d;

  logic [8:0] qm_q;
  logic       de1_q;
  logic [1:0] ctrl1_q;

  always_comb begin
    n1_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1_d = n1_d + {3'b000, data[i]};
    end
    xnor_sel = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    qm_d     = 9'd0;
    qm_d[0]  = data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = xnor_sel ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    end
    qm_d[8] = ~xnor_sel;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      qm_q    <= 9'd0;
      de1_q   <= 1'b0;
      ctrl1_q <= INIT_CTRL;
    end else begin
      qm_q    <= qm_d;
      de1_q   <= de;
      ctrl1_q <= ctrl;
    end
  end

`ifdef TMDS_TERC4_EN
  logic       island1_q;
  logic [3:0] aux1_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      island1_q <= 1'b0;
      aux1_q    <= 4'h0;
    end else begin
      island1_q <= island;
      aux1_q    <= aux;
    end
  end
`else
  logic unused_terc4;
  assign unused_terc4 = ^{island, aux};
`endif

  // ---------------- stage 2: DC balance and symbol select ----------------
  logic [3:0]        n1q;
  logic signed [6:0] diff;      // n1q - n0q, in the range -8..8
  logic signed [6:0] cnt_ext;
  logic signed [6:0] cnt_n;     // unclipped next disparity, checked against the 5-bit range
  logic [9:0]        tmds_d;
  logic signed [4:0] cnt_d;

  logic [9:0]        tmds_q;
  logic signed [4:0] cnt_q;

  always_comb begin
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1q = n1q + {3'b000, qm_q[i]};
    end
    diff    = $signed({2'b00, n1q, 1'b0}) - 7'sd8;
    cnt_ext = $signed({{2{cnt_q[4]}}, cnt_q});
    tmds_d  = ctrl_sym(ctrl1_q);
    cnt_n   = 7'sd0;

    if (!de1_q) begin
`ifdef TMDS_TERC4_EN
      if (island1_q) begin
        tmds_d = terc4_sym(aux1_q);
      end
`endif
    end else if ((cnt_q == 5'sd0) || (diff == 7'sd0)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_n  = qm_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
    end else if (((cnt_q > 5'sd0) && (diff > 7'sd0)) ||
                 ((cnt_q < 5'sd0) && (diff < 7'sd0))) begin
      // Disparity already leans the same way as this word: invert to pull back.
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_n  = cnt_ext + (qm_q[8] ? 7'sd2 : 7'sd0) - diff;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_n  = cnt_ext + diff - (qm_q[8] ? 7'sd0 : 7'sd2);
    end
    cnt_d = cnt_n[4:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmds_q <= ctrl_sym(INIT_CTRL);
      cnt_q  <= 5'sd0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert ((cnt_n >= -7'sd16) && (cnt_n <= 7'sd15))
        else $error("tmds_channel_encoder: running disparity out of 5-bit range");
    end
  end
`endif

  // Only the wire order changes; the encoding is identical in both builds.
  generate
    if (BIT_REVERSE) begin : g_rev
      for (genvar i = 0; i < 10; i++) begin : g_bit
        assign tmds[i] = tmds_q[9-i];
      end
    end else begin : g_fwd
      assign tmds = tmds_q;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_channel_encoder.sv
module tb_tmds_channel_encoder;

  localparam logic [9:0] INIT_SYM = 10'h354;
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] ISL_EXP = 10'h11E;
  localparam bit         TERC4_ON = 1'b1;
`else
  localparam logic [9:0] ISL_EXP = 10'h354;
  localparam bit         TERC4_ON = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       island;
    logic [3:0] aux;
    logic [9:0] exp_tmds;
    int         exp_cnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [9:0] tmds;
    int         cnt;
    logic       is_de;
    logic [7:0] data;
  } sb_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       island;
  logic [3:0] aux;
  logic [9:0] tmds;

  int   checks   = 0;
  int   failures = 0;
  int   m_cnt    = 0;
  sb_t  sb[$];
  vec_t tbl[31];

  tmds_channel_encoder dut (
    .clk    (clk),
    .resetn (resetn),
    .de     (de),
    .data   (data),
    .ctrl   (ctrl),
    .island (island),
    .aux    (aux),
    .tmds   (tmds)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic d_de, input logic [7:0] d,
                              input logic [1:0] c, input logic isl, input logic [3:0] a,
                              input logic [9:0] et, input int ec);
    vec_t v;
    v.rst = r; v.de = d_de; v.data = d; v.ctrl = c; v.island = isl; v.aux = a;
    v.exp_tmds = et; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic logic [9:0] m_ctrl(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] m_terc4(input logic [3:0] a);
    logic [9:0] t [16];
    t = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
          10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
          10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
          10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    return t[a];
  endfunction

  // Reference encoder for one pixel; updates the model disparity m_cnt.
  task automatic model_enc(input logic d_de, input logic [7:0] d, input logic [1:0] c,
                           input logic isl, input logic [3:0] a,
                           output logic [9:0] sym, output int cnt_after);
    int         n1, n1q, n0q;
    logic       inv;
    logic [8:0] qm;
    if (!d_de) begin
      m_cnt = 0;
      sym = (TERC4_ON && isl) ? m_terc4(a) : m_ctrl(c);
    end else begin
      n1  = $countones(d);
      inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm  = 9'd0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~inv;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (m_cnt == 0 || n1q == n0q) begin
        sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        m_cnt = m_cnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
      end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
        sym   = {1'b1, qm[8], ~qm[7:0]};
        m_cnt = m_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
        sym   = {1'b0, qm[8], qm[7:0]};
        m_cnt = m_cnt + n1q - n0q - (qm[8] ? 0 : 2);
      end
    end
    cnt_after = m_cnt;
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic check_out(input sb_t e);
    checks++;
    if (tmds !== e.tmds) begin
      failures++;
      $display("FAIL tmds item %0d: got %h expected %h", e.idx, tmds, e.tmds);
    end
    checks++;
    if ($signed(dut.cnt_q) != e.cnt) begin
      failures++;
      $display("FAIL cnt item %0d: got %0d expected %0d", e.idx, $signed(dut.cnt_q), e.cnt);
    end
    if (e.is_de) begin
      checks++;
      if (decode(tmds) !== e.data) begin
        failures++;
        $display("FAIL decode item %0d: got %h expected %h", e.idx, decode(tmds), e.data);
      end
    end
  endtask

  // Drive one pixel at the falling edge; its result is checked two falling edges later.
  task automatic drive(input vec_t v, input int idx);
    sb_t e;
    @(negedge clk);
    if (sb.size() == 2) check_out(sb.pop_front());
    resetn = ~v.rst;
    de     = v.de;
    data   = v.data;
    ctrl   = v.ctrl;
    island = v.island;
    aux    = v.aux;
    if (v.rst && sb.size() != 0) begin
      // The symbol in flight is replaced by the reset symbol at this edge.
      e = sb.pop_back();
      e.tmds = INIT_SYM; e.cnt = 0; e.is_de = 1'b0;
      sb.push_back(e);
    end
    e.idx = idx; e.tmds = v.exp_tmds; e.cnt = v.exp_cnt;
    e.is_de = v.de && !v.rst; e.data = v.data;
    sb.push_back(e);
  endtask

  initial begin
    vec_t v;
    logic [9:0] s;
    int c;

    tbl[0]  = mk(1, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[1]  = mk(1, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[2]  = mk(1, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[3]  = mk(0, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[4]  = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100, -8);
    tbl[5]  = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h3FF,  2);
    tbl[6]  = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100, -6);
    tbl[7]  = mk(0, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[8]  = mk(0, 1, 8'hFF, 2'b00, 0, 4'h0, 10'h200, -8);
    tbl[9]  = mk(0, 1, 8'hFF, 2'b00, 0, 4'h0, 10'h0FF, -2);
    tbl[10] = mk(0, 0, 8'h00, 2'b01, 0, 4'h0, 10'h0AB,  0);
    tbl[11] = mk(0, 0, 8'h00, 2'b10, 0, 4'h0, 10'h154,  0);
    tbl[12] = mk(0, 0, 8'h00, 2'b11, 0, 4'h0, 10'h2AB,  0);
    tbl[13] = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100, -8);
    tbl[14] = mk(0, 1, 8'hFF, 2'b00, 0, 4'h0, 10'h0FF, -2);
    tbl[15] = mk(0, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[16] = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100, -8);
    tbl[17] = mk(0, 0, 8'h00, 2'b11, 0, 4'h0, 10'h2AB,  0);
    tbl[18] = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100, -8);
    tbl[19] = mk(0, 1, 8'h01, 2'b00, 0, 4'h0, 10'h1FF,  0);
    tbl[20] = mk(0, 1, 8'h01, 2'b00, 0, 4'h0, 10'h1FF,  8);
    tbl[21] = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100,  0);
    tbl[22] = mk(0, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[23] = mk(0, 1, 8'h1E, 2'b00, 0, 4'h0, 10'h25F,  4);
    tbl[24] = mk(0, 1, 8'h0F, 2'b00, 0, 4'h0, 10'h105,  0);
    tbl[25] = mk(0, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[26] = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h100, -8);
    tbl[27] = mk(0, 1, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[28] = mk(1, 1, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);
    tbl[29] = mk(0, 0, 8'h00, 2'b00, 1, 4'h5, ISL_EXP,  0);
    tbl[30] = mk(0, 0, 8'h00, 2'b00, 0, 4'h0, 10'h354,  0);

    resetn = 1'b0; de = 1'b0; data = 8'h00; ctrl = 2'b00; island = 1'b0; aux = 4'h0;

    // Reset symbol must be present right after the first edge.
    @(negedge clk);
    checks++;
    if (tmds !== INIT_SYM) begin
      failures++;
      $display("FAIL reset_first_edge: got %h expected %h", tmds, INIT_SYM);
    end
    checks++;
    if ($signed(dut.cnt_q) != 0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d expected 0", $signed(dut.cnt_q));
    end

    for (int i = 0; i < 31; i++) drive(tbl[i], i);

    // Random pixel stream against the reference model.
    m_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      v.rst    = 1'b0;
      v.de     = ($urandom_range(0, 3) != 0);
      v.data   = 8'($urandom_range(0, 255));
      v.ctrl   = 2'($urandom_range(0, 3));
      v.island = 1'($urandom_range(0, 1));
      v.aux    = 4'($urandom_range(0, 15));
      model_enc(v.de, v.data, v.ctrl, v.island, v.aux, s, c);
      v.exp_tmds = s;
      v.exp_cnt  = c;
      drive(v, 100 + i);
    end

    while (sb.size() != 0) begin
      @(negedge clk);
      check_out(sb.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
